// File: rtl/irr_priority_resolver.sv
// Interrupt request register with input synchronisers and a rotating-priority resolver.
// Delivers a registered one-hot winner and INT request; both hold while an INTA sequence is frozen.
module irr_priority_resolver #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [2:0] RESET_LOWEST = 3'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir_in,
  input  logic       level_triggered,
  input  logic [7:0] interrupt_mask,
  input  logic       special_mask_mode,
  input  logic [7:0] in_service_register,
  input  logic       freeze,
  input  logic [7:0] clear_irr,
  input  logic       priority_rotate,
  input  logic [2:0] priority_rotate_level,
  output logic [7:0] interrupt_request_register,
  output logic [7:0] highest_priority_interrupt,
  output logic       interrupt_pending,
  output logic [2:0] lowest_priority_level
);

  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] ir_s;
  logic [7:0] ir_d_q, ir_d_d;
  logic [7:0] rise;
  logic [7:0] irr_q, irr_d;
  logic [7:0] hpi_q, hpi_d;
  logic       pend_q, pend_d;
  logic [2:0] lowest_q, lowest_d;
  logic [7:0] req;
  logic [7:0] winner;
  logic [3:0] isr_rank;
  logic       found;
  logic [2:0] lvl;
  logic       elig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= ir_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign ir_s = sync_q[SYNC_STAGES-1];
  assign rise = ir_s & ~ir_d_q;

  // Edge history is frozen with the IRR, so an edge seen during INTA is
  // taken once freeze drops, provided the line is still high then.
  always_comb begin
    ir_d_d = ir_d_q;
    irr_d  = irr_q;
    if (!freeze) begin
      ir_d_d = ir_s;
      irr_d  = level_triggered ? ir_s : ((irr_q | rise) & ir_s);
    end
    irr_d = irr_d & ~clear_irr;
  end

  always_comb begin
    req      = irr_q & ~interrupt_mask;
    isr_rank = 4'd8;
    winner   = '0;
    found    = 1'b0;
    lvl      = '0;
    elig     = 1'b0;
    for (int r = 0; r < 8; r++) begin
      lvl = lowest_q + 3'(r + 1);
      if (in_service_register[lvl] && (isr_rank == 4'd8)) isr_rank = 4'(r);
    end
    for (int r = 0; r < 8; r++) begin
      lvl = lowest_q + 3'(r + 1);
      if (special_mask_mode)
        elig = req[lvl] & ~(in_service_register[lvl] & ~interrupt_mask[lvl]);
      else
        elig = req[lvl] && (4'(r) < isr_rank);
      if (elig && !found) begin
        winner[lvl] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    hpi_d    = hpi_q;
    pend_d   = pend_q;
    lowest_d = lowest_q;
    if (!freeze) begin
      hpi_d  = winner;
      pend_d = |winner;
    end
    if (priority_rotate) lowest_d = priority_rotate_level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_d_q   <= '0;
      irr_q    <= '0;
      hpi_q    <= '0;
      pend_q   <= 1'b0;
      lowest_q <= RESET_LOWEST;
    end else begin
      ir_d_q   <= ir_d_d;
      irr_q    <= irr_d;
      hpi_q    <= hpi_d;
      pend_q   <= pend_d;
      lowest_q <= lowest_d;
    end
  end

  assign interrupt_request_register = irr_q;
  assign highest_priority_interrupt = hpi_q;
  assign interrupt_pending          = pend_q;
  assign lowest_priority_level      = lowest_q;

endmodule

// File: tb/tb_irr_priority_resolver.sv
// Bench for irr_priority_resolver: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a rank-based behavioural model.
module tb_irr_priority_resolver;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ir_in = '0;
  logic       level_triggered = 1'b0;
  logic [7:0] interrupt_mask = '0;
  logic       special_mask_mode = 1'b0;
  logic [7:0] in_service_register = '0;
  logic       freeze = 1'b0;
  logic [7:0] clear_irr = '0;
  logic       priority_rotate = 1'b0;
  logic [2:0] priority_rotate_level = '0;
  logic [7:0] interrupt_request_register;
  logic [7:0] highest_priority_interrupt;
  logic       interrupt_pending;
  logic [2:0] lowest_priority_level;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  irr_priority_resolver #(.SYNC_STAGES(S), .RESET_LOWEST(3'd7)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in), .level_triggered(level_triggered),
    .interrupt_mask(interrupt_mask), .special_mask_mode(special_mask_mode),
    .in_service_register(in_service_register), .freeze(freeze), .clear_irr(clear_irr),
    .priority_rotate(priority_rotate), .priority_rotate_level(priority_rotate_level),
    .interrupt_request_register(interrupt_request_register),
    .highest_priority_interrupt(highest_priority_interrupt),
    .interrupt_pending(interrupt_pending), .lowest_priority_level(lowest_priority_level));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0] m_pipe [$];
  logic [7:0] m_last;
  logic [7:0] m_irr, m_hpi;
  logic       m_pend;
  int         m_low;

  function automatic logic [7:0] pick(input logic [7:0] irr, input logic [7:0] isr,
                                      input logic [7:0] imr, input logic smm, input int low);
    logic [7:0] req;
    int top_isr;
    req = irr & ~imr;
    top_isr = 8;
    for (int r = 7; r >= 0; r--) if (isr[(low + 1 + r) % 8]) top_isr = r;
    for (int r = 0; r < 8; r++) begin
      int b;
      b = (low + 1 + r) % 8;
      if (req[b]) begin
        if (smm ? !(isr[b] && !imr[b]) : (r < top_isr)) return 8'(1 << b);
      end
    end
    return 8'h00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pipe = {};
      for (int k = 0; k < S; k++) m_pipe.push_back(8'h00);
      m_last = '0; m_irr = '0; m_hpi = '0; m_pend = 1'b0; m_low = 7;
    end else begin
      logic [7:0] line, nirr, win;
      line = m_pipe[S-1];
      win  = pick(m_irr, in_service_register, interrupt_mask, special_mask_mode, m_low);
      nirr = m_irr;
      if (!freeze) begin
        nirr = level_triggered ? line : ((m_irr | (line & ~m_last)) & line);
        m_last = line;
        m_hpi  = win;
        m_pend = (win != 0);
      end
      m_irr = nirr & ~clear_irr;
      if (priority_rotate) m_low = priority_rotate_level;
      m_pipe.push_front(ir_in);
      void'(m_pipe.pop_back());
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_irr", interrupt_request_register, m_irr);
      chk("model_hpi", highest_priority_interrupt, m_hpi);
      chk("model_pend", {7'b0, interrupt_pending}, {7'b0, m_pend});
      chk("model_low", {5'b0, lowest_priority_level}, 8'(m_low));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rotate(input logic [2:0] lv);
    priority_rotate = 1'b1; priority_rotate_level = lv;
    cyc(1);
    priority_rotate = 1'b0;
  endtask

  initial begin
    // 1: reset with toggling inputs, then release
    for (int i = 0; i < 4; i++) begin
      ir_in = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc(1);
    end
    cmp_en = 1'b1;
    chk("rst_irr", interrupt_request_register, 8'h00);
    chk("rst_hpi", highest_priority_interrupt, 8'h00);
    chk("rst_pend", {7'b0, interrupt_pending}, 8'h00);
    chk("rst_low", {5'b0, lowest_priority_level}, 8'h07);
    ir_in = 8'hFF; rst_n = 1'b1;
    cyc(3);
    chk("t1_pend_c3", {7'b0, interrupt_pending}, 8'h00);
    cyc(1);
    chk("t1_pend_c4", {7'b0, interrupt_pending}, 8'h01);
    chk("t1_hpi", highest_priority_interrupt, 8'h01);

    // 2: edge mode, 00 -> 24
    ir_in = 8'h00; cyc(5);
    chk("t2_idle", highest_priority_interrupt, 8'h00);
    ir_in = 8'h24; cyc(3);
    chk("t2_irr_c3", interrupt_request_register, 8'h24);
    chk("t2_pend_c3", {7'b0, interrupt_pending}, 8'h00);
    cyc(1);
    chk("t2_hpi", highest_priority_interrupt, 8'h04);
    chk("t2_pend", {7'b0, interrupt_pending}, 8'h01);

    // 3: in-service blocking and special mask mode
    ir_in = 8'h03; in_service_register = 8'h04; cyc(5);
    chk("t3_irr", interrupt_request_register, 8'h03);
    chk("t3_hpi_a", highest_priority_interrupt, 8'h01);
    ir_in = 8'h08; cyc(5);
    chk("t3_hpi_b", highest_priority_interrupt, 8'h00);
    special_mask_mode = 1'b1; cyc(2);
    chk("t3_hpi_smm", highest_priority_interrupt, 8'h08);
    special_mask_mode = 1'b0; in_service_register = 8'h00;

    // 4: rotation
    ir_in = 8'h09; cyc(5);
    chk("t4_pre", highest_priority_interrupt, 8'h01);
    rotate(3'd2);
    chk("t4_low2", {5'b0, lowest_priority_level}, 8'h02);
    cyc(1);
    chk("t4_hpi_rot2", highest_priority_interrupt, 8'h08);
    rotate(3'd7);
    cyc(1);
    chk("t4_hpi_rot7", highest_priority_interrupt, 8'h01);

    // 5: freeze with clear and new request
    ir_in = 8'h04; cyc(5);
    chk("t5_pre", highest_priority_interrupt, 8'h04);
    freeze = 1'b1; ir_in = 8'h06; clear_irr = 8'h04;
    cyc(1);
    clear_irr = 8'h00;
    chk("t5_irr_clr", interrupt_request_register, 8'h00);
    cyc(4);
    chk("t5_irr_frz", interrupt_request_register, 8'h00);
    chk("t5_hpi_held", highest_priority_interrupt, 8'h04);
    freeze = 1'b0; cyc(1);
    chk("t5_irr_rel", interrupt_request_register, 8'h02);
    cyc(1);
    chk("t5_hpi_rel", highest_priority_interrupt, 8'h02);

    // 6: level and edge mode on IR5, then masking
    ir_in = 8'h00; cyc(5);
    level_triggered = 1'b1; ir_in = 8'h20; cyc(3);
    chk("t6_lvl_set", interrupt_request_register, 8'h20);
    cyc(1);
    ir_in = 8'h00; cyc(3);
    chk("t6_lvl_clr", interrupt_request_register, 8'h00);
    chk("t6_pend_c3", {7'b0, interrupt_pending}, 8'h01);
    cyc(1);
    chk("t6_pend_c4", {7'b0, interrupt_pending}, 8'h00);
    level_triggered = 1'b0; ir_in = 8'h20; cyc(5);
    chk("t6_edge_set", interrupt_request_register, 8'h20);
    ir_in = 8'h00; cyc(3);
    chk("t6_edge_clr", interrupt_request_register, 8'h00);
    ir_in = 8'h20; cyc(5);
    chk("t6_pend_on", {7'b0, interrupt_pending}, 8'h01);
    interrupt_mask = 8'h20; cyc(2);
    chk("t6_masked", {7'b0, interrupt_pending}, 8'h00);
    interrupt_mask = 8'h00;

    // asynchronous reset mid-operation
    rotate(3'd4); cyc(3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_irr", interrupt_request_register, 8'h00);
    chk("arst_pend", {7'b0, interrupt_pending}, 8'h00);
    chk("arst_low", {5'b0, lowest_priority_level}, 8'h07);
    cyc(2);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ir_in = ir_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(40) == 0) level_triggered = ~level_triggered;
      if ($urandom_range(10) == 0) interrupt_mask = 8'($urandom) & 8'($urandom);
      if ($urandom_range(15) == 0) special_mask_mode = ~special_mask_mode;
      if ($urandom_range(6) == 0) in_service_register = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if ($urandom_range(12) == 0) freeze = ~freeze;
      clear_irr = ($urandom_range(6) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00;
      priority_rotate = ($urandom_range(9) == 0);
      priority_rotate_level = 3'($urandom_range(7));
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end else begin
        cyc(1);
      end
    end
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
